// File: rtl/io_debounce_bank_pkg.sv
// io_debounce_bank_pkg
//   Shared definitions for the debounce bank: the default sample tick rate
//   and a width helper for counters that must hold the values 0..max_val.
package io_debounce_bank_pkg;

  localparam int unsigned IO_DEFAULT_TICK_HZ = 1000;

  // Bits needed to represent 0..max_val; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/io_debounce_chan.sv
// io_debounce_chan
//   One debounce channel: two-flop synchroniser, tick-counted stability
//   filter, debounced level and one-cycle rise/fall strobes.
// Ports
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en           : 0 freezes the filter and discards progress
//   i_tick         : shared sample tick from the prescaler
//   i_in           : raw asynchronous input
//   o_level        : debounced level
//   o_rise/o_fall  : one-cycle strobes in the first cycle o_level changes
module io_debounce_chan
  import io_debounce_bank_pkg::*;
#(
  parameter int unsigned PARAM_DEBOUNCE_TICKS = 10,
  parameter logic        PARAM_INIT_LEVEL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_tick,
  input  logic i_in,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned CW = cnt_width(PARAM_DEBOUNCE_TICKS);

  logic          s0_q, s1_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Any cycle where the synchronised input agrees with the accepted level
  // cancels progress, so a bounce back restarts the full window.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s1_q == level_q) begin
      cnt_d = '0;
    end else if (!i_en) begin
      cnt_d = '0;
    end else if (i_tick && (cnt_q == CW'(PARAM_DEBOUNCE_TICKS - 1))) begin
      level_d = s1_q;
      cnt_d   = '0;
      rise_d  = s1_q;
      fall_d  = ~s1_q;
    end else if (i_tick) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s0_q    <= PARAM_INIT_LEVEL;
      s1_q    <= PARAM_INIT_LEVEL;
      cnt_q   <= '0;
      level_q <= PARAM_INIT_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s0_q    <= i_in;
      s1_q    <= s0_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

endmodule

// File: rtl/io_debounce_bank.sv
// io_debounce_bank
//   Multi-channel debouncer for mechanical inputs. A single prescaler
//   generates a one-cycle sample tick every DIV = PARAM_FREQ/PARAM_TICK_HZ
//   cycles; every channel filters against that shared tick.
// Ports
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en           : 1 = filtering active, 0 = prescaler held, progress cleared
//   i_in[N]        : raw asynchronous inputs
//   o_level[N]     : debounced levels
//   o_rise/o_fall  : per-channel one-cycle acceptance strobes
//   o_any          : OR of all strobes, same cycle
module io_debounce_bank
  import io_debounce_bank_pkg::*;
#(
  parameter int unsigned PARAM_FREQ           = 10000000,
  parameter int unsigned PARAM_TICK_HZ        = IO_DEFAULT_TICK_HZ,
  parameter int unsigned PARAM_DEBOUNCE_TICKS = 10,
  parameter int unsigned PARAM_CHANNELS       = 4,
  parameter logic [PARAM_CHANNELS-1:0] PARAM_INIT_LEVEL = '0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic [PARAM_CHANNELS-1:0] i_in,
  output logic [PARAM_CHANNELS-1:0] o_level,
  output logic [PARAM_CHANNELS-1:0] o_rise,
  output logic [PARAM_CHANNELS-1:0] o_fall,
  output logic                      o_any
);

  localparam int unsigned DIV = PARAM_FREQ / PARAM_TICK_HZ;
  localparam int unsigned PW  = cnt_width(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("io_debounce_bank: PARAM_FREQ/PARAM_TICK_HZ must be >= 2");
  end
  if (PARAM_DEBOUNCE_TICKS < 1) begin : g_bad_dt
    $error("io_debounce_bank: PARAM_DEBOUNCE_TICKS must be >= 1");
  end
  if (PARAM_CHANNELS < 1) begin : g_bad_ch
    $error("io_debounce_bank: PARAM_CHANNELS must be >= 1");
  end

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  // Held at zero while disabled so re-enabling always starts a full period.
  always_comb begin
    tick  = 1'b0;
    pre_d = '0;
    if (i_en) begin
      if (pre_q == PW'(DIV - 1)) begin
        tick  = 1'b1;
        pre_d = '0;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar g = 0; g < PARAM_CHANNELS; g++) begin : g_chan
    io_debounce_chan #(
      .PARAM_DEBOUNCE_TICKS (PARAM_DEBOUNCE_TICKS),
      .PARAM_INIT_LEVEL     (PARAM_INIT_LEVEL[g])
    ) u_chan (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (i_en),
      .i_tick  (tick),
      .i_in    (i_in[g]),
      .o_level (o_level[g]),
      .o_rise  (o_rise[g]),
      .o_fall  (o_fall[g])
    );
  end

  assign o_any = |(o_rise | o_fall);

endmodule

// File: tb/tb_io_debounce_bank.sv
module tb_io_debounce_bank;

  localparam int DIV = 10;
  localparam int DT  = 4;
  localparam int N   = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b1;
  logic [N-1:0] din = '0;
  logic [N-1:0] o_level, o_rise, o_fall;
  logic         o_any;

  io_debounce_bank #(
    .PARAM_FREQ           (1000),
    .PARAM_TICK_HZ        (100),
    .PARAM_DEBOUNCE_TICKS (DT),
    .PARAM_CHANNELS       (N),
    .PARAM_INIT_LEVEL     (4'b0000)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .i_in    (din),
    .o_level (o_level),
    .o_rise  (o_rise),
    .o_fall  (o_fall),
    .o_any   (o_any)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      if (fails < 40) $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: an input is accepted on a tick when the DT most recent ticks all
  // fall after the last cycle in which the synchronised input agreed with the
  // accepted level (or filtering was disabled). Ticks occur on every DIV-th
  // consecutive enabled cycle.
  int           cyc = 0;
  int           en_run = 0;
  int           tickq[$];
  int           last_break[N];
  logic [N-1:0] m_s0 = '0, m_s1 = '0, m_lvl = '0, m_rise = '0, m_fall = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s0 = '0; m_s1 = '0; m_lvl = '0; m_rise = '0; m_fall = '0;
      en_run = 0;
      tickq.delete();
      for (int k = 0; k < N; k++) last_break[k] = cyc;
    end else begin
      logic tick;
      cyc++;
      en_run = en ? en_run + 1 : 0;
      tick = en && (en_run % DIV == 0);
      if (tick) begin
        tickq.push_back(cyc);
        if (tickq.size() > DT) void'(tickq.pop_front());
      end
      m_rise = '0;
      m_fall = '0;
      for (int k = 0; k < N; k++) begin
        if (m_s1[k] == m_lvl[k] || !en) begin
          last_break[k] = cyc;
        end else if (tick && tickq.size() >= DT && tickq[tickq.size() - DT] > last_break[k]) begin
          m_lvl[k]  = m_s1[k];
          m_rise[k] = m_s1[k];
          m_fall[k] = ~m_s1[k];
          last_break[k] = cyc;
        end
      end
      m_s1 = m_s0;
      m_s0 = din;
    end
  end

  logic cmp_on = 1'b0;
  int   rise_cnt[N];
  int   fall_cnt[N];

  always @(negedge clk) begin
    if (rst_n && cmp_on) begin
      chk("model_level", o_level, m_lvl);
      chk("model_rise", o_rise, m_rise);
      chk("model_fall", o_fall, m_fall);
      chk("model_any", o_any, |(m_rise | m_fall));
      for (int k = 0; k < N; k++) begin
        rise_cnt[k] += int'(o_rise[k]);
        fall_cnt[k] += int'(o_fall[k]);
      end
    end
  end

  task automatic wait_level(input int k, input logic v, input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_level[k] !== v && n < max);
    chk($sformatf("wait_level_ch%0d", k), o_level[k], v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rs, fs;
    for (int k = 0; k < N; k++) begin rise_cnt[k] = 0; fall_cnt[k] = 0; end

    // Reset held while inputs toggle
    repeat (3) @(negedge clk);
    din = 4'b1111;
    repeat (3) @(negedge clk);
    chk("reset_level", o_level, 4'b0000);
    chk("reset_rise", o_rise, 4'b0000);
    chk("reset_fall", o_fall, 4'b0000);
    chk("reset_any", o_any, 1'b0);
    din = 4'b0101;
    @(negedge clk);
    chk("reset_level2", o_level, 4'b0000);
    din = 4'b0000;
    @(negedge clk);

    // Clean edge on ch0, applied at reset release: ticks at 10,20,30,40
    rst_n = 1'b1;
    cmp_on = 1'b1;
    din[0] = 1'b1;
    wait_level(0, 1'b1, 60, n);
    chk("clean_latency", n, 40);
    chk("clean_rise", o_rise, 4'b0001);
    chk("clean_any", o_any, 1'b1);
    chk("clean_others", o_level, 4'b0001);
    @(negedge clk);
    chk("clean_rise_drop", o_rise, 4'b0000);
    chk("clean_any_drop", o_any, 1'b0);
    chk("clean_rise_count", rise_cnt[0], 1);

    // Bounce on ch1: 25-cycle pulse too short, then stable high
    din[1] = 1'b1;
    repeat (25) @(negedge clk);
    din[1] = 1'b0;
    repeat (5) @(negedge clk);
    chk("bounce_no_strobe", rise_cnt[1], 0);
    din[1] = 1'b1;
    wait_level(1, 1'b1, 80, n);
    chk("bounce_latency_range", (n >= 33 && n <= 42), 1'b1);
    @(negedge clk);
    chk("bounce_single_rise", rise_cnt[1], 1);

    // Simultaneous rise then fall on ch2/ch3
    din[3:2] = 2'b11;
    wait_level(3, 1'b1, 60, n);
    chk("simul_rise_level", o_level[3:2], 2'b11);
    chk("simul_rise_strobe", o_rise[3:2], 2'b11);
    @(negedge clk);
    din[3:2] = 2'b00;
    wait_level(2, 1'b0, 60, n);
    chk("simul_fall_strobe", o_fall[3:2], 2'b11);
    chk("simul_fall_level", o_level[3:2], 2'b00);
    chk("simul_fall_rise_low", o_rise, 4'b0000);

    // Freeze: ch0 differs for 100 cycles with filtering disabled
    @(negedge clk);
    en = 1'b0;
    din[0] = 1'b0;
    repeat (100) @(negedge clk);
    chk("freeze_level", o_level[0], 1'b1);
    chk("freeze_no_fall", fall_cnt[0], 0);
    en = 1'b1;
    wait_level(0, 1'b0, 60, n);
    chk("unfreeze_latency", n, 40);
    chk("unfreeze_fall", o_fall, 4'b0001);

    // Reset in the middle of ch1 counting toward a fall
    @(negedge clk);
    din[1] = 1'b0;
    repeat (25) @(negedge clk);
    chk("midcount_level_before", o_level[1], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midreset_level", o_level, 4'b0000);
    chk("midreset_strobes", {o_rise, o_fall, o_any}, 9'd0);
    rs = 0; fs = 0;
    for (int k = 0; k < N; k++) begin rs += rise_cnt[k]; fs += fall_cnt[k]; end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("post_reset_level", o_level, 4'b0000);
    begin
      int rs2, fs2;
      rs2 = 0; fs2 = 0;
      for (int k = 0; k < N; k++) begin rs2 += rise_cnt[k]; fs2 += fall_cnt[k]; end
      chk("post_reset_no_rise", rs2, rs);
      chk("post_reset_no_fall", fs2, fs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
